red_pitaya_route_sequencer: RTL



---
 rtl/red_pitaya_route_seq_pkg.sv | 32 +++
 rtl/red_pitaya_route_seq_table.sv | 38 +++
 rtl/red_pitaya_route_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_route_seq_pkg.sv
// Shared definitions for the route sequencer: FSM encoding, slave register map,
// CTRL bit positions and the routing-address helper.
package red_pitaya_route_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StIssue = 2'd2,
    StWait  = 2'd3
  } seq_state_e;

  // Slave register offsets
  localparam logic [15:0] RegCtrl   = 16'h0000;
  localparam logic [15:0] RegStatus = 16'h0004;
  localparam logic [15:0] RegLen    = 16'h0008;

  // Table pages: 0x100 + 4k holds ENTRY_ADDR[k], 0x200 + 4k holds ENTRY_DATA[k]
  localparam logic [7:0] PageEntryAddr = 8'h01;
  localparam logic [7:0] PageEntryData = 8'h02;

  // CTRL bits (self-clearing strobes)
  localparam int unsigned CtrlArmBit    = 0;
  localparam int unsigned CtrlSwTrigBit = 1;
  localparam int unsigned CtrlAbortBit  = 2;

  // Only bits 19:0 of an entry (module index << 16 | offset) are routed.
  function automatic logic [31:0] route_addr(input logic [31:0] base,
                                             input logic [31:0] entry);
    return base + {12'h000, entry[19:0]};
  endfunction

endpackage

// File: rtl/red_pitaya_route_seq_table.sv
// DEPTH x {addr, data} register file: one write port, two asynchronous read ports
// (slave readback and sequencer). Contents are deliberately not reset.
module red_pitaya_route_seq_table #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic                     wsel_i,   // 0: address word, 1: data word
  input  logic [$clog2(DEPTH)-1:0] widx_i,
  input  logic [31:0]              wdata_i,
  input  logic [$clog2(DEPTH)-1:0] ra_idx_i,
  output logic [31:0]              ra_addr_o,
  output logic [31:0]              ra_data_o,
  input  logic [$clog2(DEPTH)-1:0] rb_idx_i,
  output logic [31:0]              rb_addr_o,
  output logic [31:0]              rb_data_o
);

  logic [31:0] addr_mem_q [DEPTH];
  logic [31:0] data_mem_q [DEPTH];

  // Single write port selects the address or data bank
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      if (wsel_i) begin
        data_mem_q[widx_i] <= wdata_i;
      end else begin
        addr_mem_q[widx_i] <= wdata_i;
      end
    end
  end

  assign ra_addr_o = addr_mem_q[ra_idx_i];
  assign ra_data_o = data_mem_q[ra_idx_i];
  assign rb_addr_o = addr_mem_q[rb_idx_i];
  assign rb_data_o = data_mem_q[rb_idx_i];

endmodule

// File: rtl/red_pitaya_route_sequencer.sv
// Route sequencer: on a trigger, replays a table of (address, data) writes onto the
// DSP routing bus, waiting for an acknowledge after each one.
module red_pitaya_route_sequencer
  import red_pitaya_route_seq_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [31:0] BASE_ADDR   = 32'h4030_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trig_i,
  // PS-side slave bus
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        ack,
  // DSP routing bus master
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_wen,
  input  logic        m_ack_i,
  // Status
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned LenW = IdxW + 1;
  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

  seq_state_e      state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [LenW-1:0] len_q, len_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            trig_q;
  logic [31:0]     m_addr_q, m_addr_d;
  logic [31:0]     m_wdata_q, m_wdata_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            busy;
  logic            ctrl_wr, len_wr, idx_valid, ent_addr_hit, ent_data_hit;
  logic            arm, swtrig, abort, trig_rise, last_entry;
  logic [IdxW-1:0] bus_idx;
  logic            tab_we;
  logic [31:0]     ra_addr, ra_data, seq_addr, seq_data;
  logic [31:0]     status_val, rd_val;

  assign busy = (state_q != StIdle);

  // Slave address decode and CTRL strobes
  always_comb begin
    bus_idx      = addr[IdxW+1:2];
    idx_valid    = (addr[1:0] == 2'b00) && (32'(addr[7:2]) < DEPTH);
    ent_addr_hit = (addr[15:8] == PageEntryAddr) && idx_valid;
    ent_data_hit = (addr[15:8] == PageEntryData) && idx_valid;
    ctrl_wr      = wen && (addr == RegCtrl);
    len_wr       = wen && (addr == RegLen);
    arm          = ctrl_wr && wdata[CtrlArmBit];
    swtrig       = ctrl_wr && wdata[CtrlSwTrigBit];
    abort        = ctrl_wr && wdata[CtrlAbortBit];
    trig_rise    = trig_i && !trig_q;
    // Table is frozen while a sequence runs
    tab_we       = wen && (ent_addr_hit || ent_data_hit) && !busy;
    last_entry   = ({1'b0, ptr_q} == (len_q - LenW'(1)));
  end

  red_pitaya_route_seq_table #(
    .DEPTH (DEPTH)
  ) u_table (
    .clk_i     (clk_i),
    .we_i      (tab_we),
    .wsel_i    (ent_data_hit),
    .widx_i    (bus_idx),
    .wdata_i   (wdata),
    .ra_idx_i  (bus_idx),
    .ra_addr_o (ra_addr),
    .ra_data_o (ra_data),
    .rb_idx_i  (ptr_d),
    .rb_addr_o (seq_addr),
    .rb_data_o (seq_data)
  );

  // Sequencer FSM next-state, pointer, timeout, LEN and status flags
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    len_d   = len_q;

    if (len_wr && !busy) begin
      len_d = (wdata > 32'(DEPTH)) ? LenW'(DEPTH) : LenW'(wdata);
    end

    if (arm) begin
      err_d = 1'b0;
    end

    if (abort) begin
      // Abort beats any trigger or acknowledge arriving in the same cycle
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (arm) begin
            if (len_q == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = StArmed;
            end
          end
        end
        StArmed: begin
          if (swtrig || trig_rise) begin
            state_d = StIssue;
            ptr_d   = '0;
          end
        end
        StIssue: begin
          state_d = StWait;
          cnt_d   = '0;
        end
        StWait: begin
          if (m_ack_i) begin
            if (last_entry) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              ptr_d   = ptr_q + IdxW'(1);
              state_d = StIssue;
            end
          end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Master address/data are loaded on entry to ISSUE and held afterwards
  always_comb begin
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    if (state_d == StIssue) begin
      m_addr_d  = route_addr(BASE_ADDR, seq_addr);
      m_wdata_d = seq_data;
    end
  end

  // Slave readback mux and one-cycle acknowledge
  always_comb begin
    status_val = 32'(ptr_q) | (32'(err_q) << IdxW) | (32'(state_q) << (IdxW + 1));
    rd_val     = '0;
    if (addr == RegStatus) begin
      rd_val = status_val;
    end else if (addr == RegLen) begin
      rd_val = 32'(len_q);
    end else if (ent_addr_hit) begin
      rd_val = ra_addr;
    end else if (ent_data_hit) begin
      rd_val = ra_data;
    end
    rdata_d = ren ? rd_val : rdata_q;
    ack_d   = wen || ren;
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      trig_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
      trig_q    <= trig_i;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  // m_wen decodes straight from the state so reset removes it asynchronously
  assign m_wen   = (state_q == StIssue);
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign busy_o  = busy;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;

endmodule
